// File: rtl/echo_fx_if.sv
// AXI-Stream style sample channel: data, valid and ready only.
// The master drives data/valid and the slave drives ready.
interface axis_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/echo_fx.sv
// Stereo feedback echo: y[n] = sat(x[n] + ((g * y[n-DEPTH]) >>> 8)) using an interleaved
// circular buffer, so each channel only hears its own history. Buffer is zero-filled after reset.
module echo_fx #(
    parameter int DATA_WIDTH   = 8,
    parameter int DELAY_FRAMES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    axis_if.slave       axis_in,
    axis_if.master      axis_out,
    input  logic [7:0]  gain,
    input  logic        bypass,
    output logic        clearing
);
    localparam int DEPTH = 2 * DELAY_FRAMES;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW    = DATA_WIDTH + 9;
    localparam logic signed [SW-1:0] SMAX = SW'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SMIN = -SMAX - SW'(1);

    typedef enum logic [2:0] {CLEAR, IDLE, READ, CALC, OUT} state_t;

    state_t                        state_reg;
    logic [PW-1:0]                 ptr_reg;
    logic [PW-1:0]                 clr_addr_reg;
    logic signed [DATA_WIDTH-1:0]  x_reg;
    logic [7:0]                    gain_reg;
    logic                          bypass_reg;
    logic                          wr_pend_reg;
    logic                          tready_reg;
    logic                          tvalid_reg;
    logic [DATA_WIDTH-1:0]         tdata_reg;
    logic                          clearing_reg;

    logic [DATA_WIDTH-1:0]         mem [DEPTH];
    logic [DATA_WIDTH-1:0]         rd_data_reg;

    logic                          mem_we;
    logic [PW-1:0]                 mem_waddr;
    logic [DATA_WIDTH-1:0]         mem_wdata;
    logic                          mem_re;

    logic signed [SW-1:0]          prod;
    logic signed [SW-1:0]          sum_w;
    logic [DATA_WIDTH-1:0]         y_next;

    // One port access per cycle at most: CLEAR/OUT write, READ reads.
    always_comb begin
        mem_we    = (state_reg == CLEAR) || ((state_reg == OUT) && wr_pend_reg);
        mem_waddr = (state_reg == CLEAR) ? clr_addr_reg : ptr_reg;
        mem_wdata = (state_reg == CLEAR) ? '0 : tdata_reg;
        mem_re    = (state_reg == READ);
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
        if (mem_re)
            rd_data_reg <= mem[ptr_reg];
    end

    // The sum is kept at product width so saturation is a plain range compare.
    always_comb begin
        prod  = $signed(rd_data_reg) * $signed({1'b0, gain_reg});
        sum_w = $signed({{9{x_reg[DATA_WIDTH-1]}}, x_reg}) + (prod >>> 8);
        if (bypass_reg)
            y_next = x_reg;
        else if (sum_w > SMAX)
            y_next = SMAX[DATA_WIDTH-1:0];
        else if (sum_w < SMIN)
            y_next = SMIN[DATA_WIDTH-1:0];
        else
            y_next = sum_w[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= CLEAR;
            ptr_reg      <= '0;
            clr_addr_reg <= '0;
            x_reg        <= '0;
            gain_reg     <= '0;
            bypass_reg   <= 1'b0;
            wr_pend_reg  <= 1'b0;
            tready_reg   <= 1'b0;
            tvalid_reg   <= 1'b0;
            tdata_reg    <= '0;
            clearing_reg <= 1'b1;
        end else begin
            case (state_reg)
                CLEAR: begin
                    clr_addr_reg <= clr_addr_reg + PW'(1);
                    if (clr_addr_reg == PW'(DEPTH - 1)) begin
                        clr_addr_reg <= '0;
                        clearing_reg <= 1'b0;
                        tready_reg   <= 1'b1;
                        state_reg    <= IDLE;
                    end
                end
                IDLE: begin
                    if (axis_in.tvalid) begin
                        x_reg      <= $signed(axis_in.tdata);
                        gain_reg   <= gain;
                        bypass_reg <= bypass;
                        tready_reg <= 1'b0;
                        state_reg  <= READ;
                    end
                end
                READ: state_reg <= CALC;
                CALC: begin
                    tdata_reg   <= y_next;
                    tvalid_reg  <= 1'b1;
                    wr_pend_reg <= 1'b1;
                    state_reg   <= OUT;
                end
                OUT: begin
                    wr_pend_reg <= 1'b0;
                    if (axis_out.tready) begin
                        tvalid_reg <= 1'b0;
                        ptr_reg    <= (ptr_reg == PW'(DEPTH - 1)) ? '0 : ptr_reg + PW'(1);
                        tready_reg <= 1'b1;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= CLEAR;
            endcase
        end
    end

    assign axis_in.tready  = tready_reg;
    assign axis_out.tvalid = tvalid_reg;
    assign axis_out.tdata  = tdata_reg;
    assign clearing        = clearing_reg;
endmodule

// File: doc/echo_fx.md
# echo_fx

Stereo feedback-echo stage between the I2S receive stream and the I2S transmit stream. It consumes interleaved left/right samples from the I2S block's receive AXI-Stream master and produces processed samples for its transmit AXI-Stream slave. It computes y[n] = sat(x[n] + ((g · y[n − 2·DELAY_FRAMES]) >>> 8)) using an on-chip circular buffer. Because the buffer is interleaved, each channel echoes only its own history.

## Interface

- DATA_WIDTH, 8: sample width; signed two's complement.
- DELAY_FRAMES, 4096: echo delay in stereo frames. Buffer DEPTH = 2·DELAY_FRAMES entries of DATA_WIDTH bits. Pointer width is clog2(DEPTH).

- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- axis_in  axis_if.slave  DATA_WIDTH  input samples; uses tdata, tvalid, tready.
- axis_out  axis_if.master  DATA_WIDTH  output samples; uses tdata, tvalid, tready.
- gain  in  8  feedback gain g, unsigned Q0.8 (0 … 255/256). Sampled at the input handshake.
- bypass  in  1  when 1, y = x. Sampled at the input handshake.
- clearing  out  1  high while the buffer is being zero-filled.

## Operation

- FSM states: CLEAR, IDLE, READ, CALC, OUT.
- Reset (rst low, asynchronous):
  - state = CLEAR, ptr = 0, clr_addr = 0.
  - axis_in.tready = 0, axis_out.tvalid = 0, axis_out.tdata = 0, clearing = 1.
- CLEAR:
  - Writes 0 to mem[clr_addr], one entry per cycle, addresses 0 … DEPTH−1.
  - After writing DEPTH−1, moves to IDLE and clearing falls.
  - axis_in.tready = 0 throughout.
- IDLE:
  - axis_in.tready = 1.
  - On tvalid && tready: register x, gain and bypass, then go to READ.
- READ: issues a synchronous read of mem[ptr] (1-cycle read latency), then go to CALC.
- CALC:
  - d = read data.
  - p = d × {1'b0, gain}, signed, DATA_WIDTH+9 bits.
  - s = x + (p >>> 8). The shift is arithmetic, so it floors. s is DATA_WIDTH+1 bits.
  - y = s saturated to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - If bypass is set, y = x.
  - Register y into axis_out.tdata, then go to OUT.
- OUT:
  - axis_out.tvalid = 1; tdata is held stable.
  - mem[ptr] ← y is written on the first OUT cycle only.
  - On axis_out handshake: tvalid falls, ptr advances (DEPTH−1 wraps to 0), go to IDLE.
- Channel separation: samples alternate L/R. The read location ptr holds the sample from exactly DEPTH slots earlier, which is always the same channel.
- There is no tlast or channel tagging; word order is preserved one-for-one.
- gain or bypass changes between handshakes affect only later samples.

## Timing

- Input handshake at cycle T: READ at T+1, CALC at T+2, axis_out.tvalid high at T+3.
- Maximum throughput is one sample per 4 cycles when axis_out.tready is held high.
- axis_in.tready is high only in IDLE. It is never high in the same cycle as axis_out.tvalid.
- Backpressure: tvalid and tdata stay stable until tready. The buffer write happens once, regardless of how long OUT lasts.
- Memory read/write conflicts are impossible: at most one port access occurs per cycle.
- CLEAR lasts exactly DEPTH cycles after reset release. The first tready is high at cycle DEPTH.
- Reset asserted mid-operation: any pending output sample is dropped (tvalid falls asynchronously). The full CLEAR sequence repeats, so no stale echo survives.
- Zero gain: output equals input, but the buffer is still written.

## Test plan

- **Clear:** DELAY_FRAMES=4 (DEPTH=8); release rst → clearing high for 8 cycles; axis_in.tready first high on cycle 8; every buffer word reads 0.
- **Impulse echo:** DELAY_FRAMES=4, gain=128; input L=100 at index 0, all other samples 0 → output index 0 = 100, index 8 = 50, index 16 = 25, index 24 = 12. All odd (R) indices = 0.
- **Saturation:** DATA_WIDTH=8, gain=255.
  - Feed 127 repeatedly → the second echo pass outputs 127 (127+126 clipped).
  - Feed −128 repeatedly → output −128 (−128 + (−128) = −256 clipped).
- **Backpressure:** hold axis_out.tready=0 for 10 cycles while tvalid is high → tdata constant, axis_in.tready=0; only one buffer write occurs; output stream matches the no-stall reference.
- **Bypass and latency:** bypass=1, gain=255, input sequence 5, −3, 7 → outputs 5, −3, 7; each tvalid rises exactly 3 cycles after its input handshake.
- **Reset mid-operation:** assert rst while in OUT → tvalid=0 and tdata=0 immediately; after release, CLEAR repeats and a fresh impulse produces an echo with no residue from before the reset.
